// File: rtl/arith_pipe_pkg.sv
// Shared mode encodings, width helpers and a wide reference model for the
// signed three-stage arithmetic pipe.
package arith_pipe_pkg;

    localparam logic [1:0] MODE_ADD_ADD = 2'b00;
    localparam logic [1:0] MODE_SUB_ADD = 2'b01;
    localparam logic [1:0] MODE_ADD_SUB = 2'b10;
    localparam logic [1:0] MODE_SUB_SUB = 2'b11;

    function automatic int pre_w(input int w);
        return w + 1;
    endfunction

    function automatic int prod_w(input int w);
        return 2 * w + 1;
    endfunction

    function automatic int out_w(input int w);
        return 2 * w + 2;
    endfunction

    // Wide enough for the largest legal operand width, so the model never wraps.
    typedef logic signed [127:0] wide_t;

    function automatic wide_t arith_ref(input wide_t a, input wide_t b, input wide_t c,
                                        input wide_t d, input logic [1:0] mode);
        wide_t s;
        wide_t p;
        s = mode[0] ? a - b : a + b;
        p = s * c;
        return mode[1] ? p - d : p + d;
    endfunction

endpackage

// File: rtl/arith_pipe_stage.sv
// One pipeline slot: a valid bit plus a data register, with flush and
// elastic load/drain control supplied by the enclosing pipe.
module arith_pipe_stage #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              load,
    input  logic              nxt_adv,
    input  logic [DATA_W-1:0] d_in,
    output logic              vld,
    output logic [DATA_W-1:0] q
);

    // Without a load, the slot empties only once downstream has taken the beat.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld <= 1'b0;
        end else if (flush) begin
            vld <= 1'b0;
        end else if (load) begin
            vld <= 1'b1;
        end else if (nxt_adv) begin
            vld <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= '0;
        end else if (load && !flush) begin
            q <= d_in;
        end
    end

endmodule

// File: rtl/arith_pipe_unit.sv
// Three-stage signed pipe computing y = ((a op1 b) * c) op2 d with per-beat
// mode, valid/ready backpressure, bubble collapse and synchronous flush.
module arith_pipe_unit
    import arith_pipe_pkg::*;
#(
    parameter  int W  = 8,
    localparam int OW = out_w(W)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [1:0]    mode,
    input  logic [W-1:0]  a,
    input  logic [W-1:0]  b,
    input  logic [W-1:0]  c,
    input  logic [W-1:0]  d,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [OW-1:0] y,
    output logic [1:0]    out_mode
);

    localparam int SW   = pre_w(W);
    localparam int PW   = prod_w(W);
    localparam int D0_W = SW + 2 * W + 2;
    localparam int D1_W = PW + W + 2;
    localparam int D2_W = OW + 2;

    logic vld_p0, vld_p1, vld_p2;
    logic adv_p0, adv_p1, adv_p2;
    logic load_p0, load_p1, load_p2;

    assign adv_p2   = !vld_p2 || out_ready;
    assign adv_p1   = !vld_p1 || adv_p2;
    assign adv_p0   = !vld_p0 || adv_p1;
    assign in_ready = adv_p0 && !flush;

    assign load_p0 = in_valid && in_ready;
    assign load_p1 = vld_p0 && adv_p1;
    assign load_p2 = vld_p1 && adv_p2;

    // ---- S1: pre-add/subtract, carry c, d and mode
    logic signed [W:0]   a_x, b_x, s_c;
    logic [D0_W-1:0]     q_p0;
    logic signed [W:0]   s_p0;
    logic signed [W-1:0] c_p0, d_p0;
    logic [1:0]          mode_p0;

    assign a_x = {a[W-1], a};
    assign b_x = {b[W-1], b};
    assign s_c = mode[0] ? a_x - b_x : a_x + b_x;

    arith_pipe_stage #(.DATA_W(D0_W)) u_stage_p0 (
        .clk     (clk),
        .rst     (rst),
        .flush   (flush),
        .load    (load_p0),
        .nxt_adv (adv_p1),
        .d_in    ({mode, d, c, s_c}),
        .vld     (vld_p0),
        .q       (q_p0)
    );

    assign s_p0    = q_p0[SW-1:0];
    assign c_p0    = q_p0[SW+W-1:SW];
    assign d_p0    = q_p0[SW+2*W-1:SW+W];
    assign mode_p0 = q_p0[D0_W-1:D0_W-2];

    // ---- S2: multiply, carry d and mode
    logic signed [PW-1:0] s_x, c_x, p_c;
    logic [D1_W-1:0]      q_p1;
    logic signed [PW-1:0] p_p1;
    logic signed [W-1:0]  d_p1;
    logic [1:0]           mode_p1;

    assign s_x = {{(PW-SW){s_p0[SW-1]}}, s_p0};
    assign c_x = {{(PW-W){c_p0[W-1]}}, c_p0};
    assign p_c = s_x * c_x;

    arith_pipe_stage #(.DATA_W(D1_W)) u_stage_p1 (
        .clk     (clk),
        .rst     (rst),
        .flush   (flush),
        .load    (load_p1),
        .nxt_adv (adv_p2),
        .d_in    ({mode_p0, d_p0, p_c}),
        .vld     (vld_p1),
        .q       (q_p1)
    );

    assign p_p1    = q_p1[PW-1:0];
    assign d_p1    = q_p1[PW+W-1:PW];
    assign mode_p1 = q_p1[D1_W-1:D1_W-2];

    // ---- S3: post-add/subtract into the output register
    logic signed [OW-1:0] p_x, d_x, y_c;
    logic [D2_W-1:0]      q_p2;

    assign p_x = {p_p1[PW-1], p_p1};
    assign d_x = {{(OW-W){d_p1[W-1]}}, d_p1};
    assign y_c = mode_p1[1] ? p_x - d_x : p_x + d_x;

    arith_pipe_stage #(.DATA_W(D2_W)) u_stage_p2 (
        .clk     (clk),
        .rst     (rst),
        .flush   (flush),
        .load    (load_p2),
        .nxt_adv (out_ready),
        .d_in    ({mode_p1, y_c}),
        .vld     (vld_p2),
        .q       (q_p2)
    );

    assign y         = q_p2[OW-1:0];
    assign out_mode  = q_p2[D2_W-1:D2_W-2];
    assign out_valid = vld_p2;

endmodule

// File: tb/tb_arith_pipe_unit.sv
// Directed-vector and scoreboard bench for arith_pipe_unit at W=8.
module tb_arith_pipe_unit;
    import arith_pipe_pkg::*;

    localparam int W  = 8;
    localparam int OW = 18;

    logic          clk, rst, flush, in_valid, in_ready, out_valid, out_ready;
    logic [1:0]    mode, out_mode;
    logic [W-1:0]  a, b, c, d;
    logic [OW-1:0] y;

    arith_pipe_unit #(.W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .a         (a),
        .b         (b),
        .c         (c),
        .d         (d),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .out_mode  (out_mode)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [OW-1:0] y;
        logic [1:0]    mode;
        int            cyc;
    } sb_t;

    typedef struct {
        int         a, b, c, d;
        logic [1:0] mode;
        int         y;
    } vec_t;

    sb_t           sbq[$];
    vec_t          tbl[11];
    int            total = 0;
    int            bad = 0;
    int            cyc = 0;
    int            n_ret = 0;
    bit            acc_flag = 1'b0;
    bit            chk_lat = 1'b0;
    bit            last_in_ready = 1'b0;
    logic [OW-1:0] cur_exp = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int model(input int va, input int vb, input int vc, input int vd,
                                 input logic [1:0] vm);
        logic signed [W-1:0] sa, sb, sc, sd;
        wide_t r;
        sa = va[W-1:0];
        sb = vb[W-1:0];
        sc = vc[W-1:0];
        sd = vd[W-1:0];
        r = arith_ref(wide_t'(sa), wide_t'(sb), wide_t'(sc), wide_t'(sd), vm);
        return int'(r[31:0]);
    endfunction

    // One clock: observe handshakes at the falling edge, return just after the rising edge.
    task automatic step();
        @(negedge clk);
        cyc++;
        last_in_ready = in_ready;
        acc_flag = in_valid && in_ready;
        if (out_valid) begin
            if (sbq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL spurious out_valid: y=%0h with nothing in flight", y);
            end else begin
                check("y", 64'(y), 64'(sbq[0].y));
                check("out_mode", 64'(out_mode), 64'(sbq[0].mode));
            end
        end
        if (flush) begin
            sbq.delete();
        end else begin
            if (out_valid && out_ready && sbq.size() > 0) begin
                if (chk_lat) check("latency", 64'(cyc - sbq[0].cyc), 64'd3);
                n_ret++;
                void'(sbq.pop_front());
            end
            if (acc_flag) sbq.push_back('{cur_exp, mode, cyc});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int va, input int vb, input int vc, input int vd,
                         input logic [1:0] vm, input int vy);
        a = va[W-1:0];
        b = vb[W-1:0];
        c = vc[W-1:0];
        d = vd[W-1:0];
        mode = vm;
        cur_exp = vy[OW-1:0];
    endtask

    task automatic send(input int va, input int vb, input int vc, input int vd,
                        input logic [1:0] vm, input int vy);
        drive(va, vb, vc, vd, vm, vy);
        in_valid = 1'b1;
        for (int k = 0; k < 200; k++) begin
            step();
            if (acc_flag) break;
        end
        if (!acc_flag) begin
            total++;
            bad++;
            $display("FAIL send timeout: beat not accepted within 200 cycles");
        end
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        for (int k = 0; k < n; k++) step();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int  sent, nb, flush_y, ret0;
        bit  saw_full, pend;

        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; c = '0; d = '0; mode = '0;

        tbl[0]  = '{10, 3, 4, 5, MODE_ADD_ADD, 57};
        tbl[1]  = '{10, 3, 4, 5, MODE_SUB_ADD, 33};
        tbl[2]  = '{10, 3, 4, 5, MODE_ADD_SUB, 47};
        tbl[3]  = '{10, 3, 4, 5, MODE_SUB_SUB, 23};
        tbl[4]  = '{-128, -128, -128, 127, MODE_ADD_ADD, 32895};
        tbl[5]  = '{127, -128, 127, -128, MODE_SUB_ADD, 32257};
        tbl[6]  = '{127, -128, 127, -128, MODE_SUB_SUB, 32513};
        tbl[7]  = '{-1, 1, -128, -128, MODE_ADD_SUB, 128};
        tbl[8]  = '{127, 127, 127, 127, MODE_ADD_ADD, 32385};
        tbl[9]  = '{-128, 127, 127, -128, MODE_SUB_ADD, -32513};
        tbl[10] = '{5, 7, -3, -1, MODE_SUB_SUB, 7};

        repeat (2) @(posedge clk);
        #1;
        check("reset out_valid", 64'(out_valid), 64'd0);
        check("reset y", 64'(y), 64'd0);
        check("reset out_mode", 64'(out_mode), 64'd0);
        rst = 1'b1;
        @(negedge clk);
        check("in_ready after reset", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;

        // Directed table, back-to-back with the consumer always ready.
        chk_lat = 1'b1;
        for (int i = 0; i < 11; i++)
            send(tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].d, tbl[i].mode, tbl[i].y);
        idle(5);
        chk_lat = 1'b0;
        check("table drained", 64'(sbq.size()), 64'd0);

        // Backpressure: six beats, consumer stalled for cycles 3..8.
        sent = 0;
        saw_full = 1'b0;
        for (int t = 0; t < 40; t++) begin
            in_valid = (sent < 6);
            drive(sent + 1, -sent, 3, sent * 7, 2'(sent), model(sent + 1, -sent, 3, sent * 7, 2'(sent)));
            out_ready = !(t >= 3 && t <= 8);
            step();
            if (acc_flag) sent++;
            if (in_valid && !last_in_ready) saw_full = 1'b1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        check("bp beats sent", 64'(sent), 64'd6);
        check("bp in_ready fell", 64'(saw_full), 64'd1);
        check("bp drained", 64'(sbq.size()), 64'd0);

        // Bubble collapse behind a held output.
        send(20, 1, 2, 3, MODE_ADD_ADD, model(20, 1, 2, 3, MODE_ADD_ADD));
        out_ready = 1'b0;
        idle(2);
        check("bubble X held", 64'(out_valid), 64'd1);
        send(-5, 6, 7, 8, MODE_SUB_SUB, model(-5, 6, 7, 8, MODE_SUB_SUB));
        drive(9, 9, -9, 9, MODE_ADD_SUB, model(9, 9, -9, 9, MODE_ADD_SUB));
        step();
        check("bubble Z accepted", 64'(acc_flag), 64'd1);
        in_valid = 1'b0;
        check("full stalled in_ready", 64'(in_ready), 64'd0);
        out_ready = 1'b1;
        #1;
        check("full ready in_ready", 64'(in_ready), 64'd1);
        ret0 = n_ret;
        drive(-100, 27, -77, 55, MODE_SUB_ADD, model(-100, 27, -77, 55, MODE_SUB_ADD));
        in_valid = 1'b1;
        step();
        check("full accept", 64'(acc_flag), 64'd1);
        check("full retire", 64'(n_ret - ret0), 64'd1);
        idle(5);
        check("bubble drained", 64'(sbq.size()), 64'd0);

        // Flush with three beats in flight and a fourth offered.
        send(1, 2, 3, 4, MODE_ADD_ADD, model(1, 2, 3, 4, MODE_ADD_ADD));
        send(5, 6, 7, 8, MODE_SUB_ADD, model(5, 6, 7, 8, MODE_SUB_ADD));
        send(-9, 10, -11, 12, MODE_SUB_SUB, model(-9, 10, -11, 12, MODE_SUB_SUB));
        flush_y = model(1, 2, 3, 4, MODE_ADD_ADD);
        drive(50, 50, 50, 50, MODE_ADD_ADD, model(50, 50, 50, 50, MODE_ADD_ADD));
        in_valid = 1'b1;
        flush = 1'b1;
        #1;
        check("flush in_ready", 64'(in_ready), 64'd0);
        step();
        check("flush no accept", 64'(acc_flag), 64'd0);
        flush = 1'b0;
        in_valid = 1'b0;
        check("flush out_valid", 64'(out_valid), 64'd0);
        check("flush y hold", 64'(y), 64'(flush_y[OW-1:0]));
        idle(4);
        chk_lat = 1'b1;
        send(-128, 127, -128, -128, MODE_SUB_SUB, model(-128, 127, -128, -128, MODE_SUB_SUB));
        idle(4);
        chk_lat = 1'b0;
        check("flush drained", 64'(sbq.size()), 64'd0);

        // Asynchronous reset between edges while beats are in flight.
        send(3, 4, 5, 6, MODE_ADD_ADD, model(3, 4, 5, 6, MODE_ADD_ADD));
        send(7, 8, 9, 10, MODE_ADD_SUB, model(7, 8, 9, 10, MODE_ADD_SUB));
        send(11, 12, 13, 14, MODE_SUB_ADD, model(11, 12, 13, 14, MODE_SUB_ADD));
        in_valid = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        check("async rst out_valid", 64'(out_valid), 64'd0);
        check("async rst y", 64'(y), 64'd0);
        sbq.delete();
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b1;
        idle(6);
        check("post rst in_ready", 64'(in_ready), 64'd1);

        // Random valid/ready traffic against the reference model.
        nb = 0;
        pend = 1'b0;
        for (int t = 0; t < 60000 && nb < 10000; t++) begin
            if (!pend) begin
                if ($urandom_range(0, 99) < 60) begin
                    int ra, rb, rc, rd;
                    logic [1:0] rm;
                    ra = int'($urandom_range(0, 255)) - 128;
                    rb = int'($urandom_range(0, 255)) - 128;
                    rc = int'($urandom_range(0, 255)) - 128;
                    rd = int'($urandom_range(0, 255)) - 128;
                    rm = 2'($urandom_range(0, 3));
                    drive(ra, rb, rc, rd, rm, model(ra, rb, rc, rd, rm));
                    in_valid = 1'b1;
                    pend = 1'b1;
                end else begin
                    in_valid = 1'b0;
                end
            end
            out_ready = ($urandom_range(0, 99) < 70);
            step();
            if (acc_flag) begin
                nb++;
                pend = 1'b0;
            end
        end
        out_ready = 1'b1;
        idle(6);
        check("random beats", 64'(nb), 64'd10000);
        check("random drained", 64'(sbq.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
